// File: rtl/cache_control_nway_pkg.sv
// Shared types and helpers for the N-way cache controller.
package cache_pkg;
  localparam int MAX_WAYS = 8;

  typedef enum logic [2:0] {
    CC_IDLE, CC_WRITEBACK, CC_ALLOCATE, CC_WT_WRITE, CC_FLUSH_CHK, CC_FLUSH_WB
  } cc_state_t;

  typedef logic [$clog2(MAX_WAYS)-1:0] way_idx_t;

  // Zero or exactly one bit set.
  function automatic logic onehot0(input logic [MAX_WAYS-1:0] v);
    return (v & (v - 1'b1)) == '0;
  endfunction

  function automatic way_idx_t first_one(input logic [MAX_WAYS-1:0] v);
    way_idx_t idx;
    idx = '0;
    for (int i = MAX_WAYS-1; i >= 0; i--)
      if (v[i]) idx = way_idx_t'(i);
    return idx;
  endfunction
endpackage

// File: rtl/cache_control_nway_victim_sel.sv
// Replacement victim: lowest-index invalid way, else the LRU way.
module cache_victim_sel #(
  parameter int WAYS = 4,
  localparam int WW = $clog2(WAYS)
) (
  input  logic [WAYS-1:0] is_valid,
  input  logic [WW-1:0]   lru_way,
  output logic [WW-1:0]   victim
);
  always_comb begin
    victim = lru_way;
    for (int i = WAYS-1; i >= 0; i--)
      if (!is_valid[i]) victim = WW'(i);
  end
endmodule

// File: rtl/cache_control_nway.sv
// N-way set-associative cache control FSM with write-back/write-through
// policy selection and a set-walking flush of dirty lines.
module cache_control_nway
  import cache_pkg::*;
#(
  parameter int WAYS       = 4,
  parameter int SETS       = 16,
  parameter int WRITE_BACK = 1,
  localparam int WW = $clog2(WAYS),
  localparam int SW = $clog2(SETS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_read,
  input  logic            cpu_write,
  input  logic            cpu_flush,
  input  logic [WAYS-1:0] hit_way,
  input  logic [WAYS-1:0] is_valid,
  input  logic [WAYS-1:0] is_dirty,
  input  logic [WW-1:0]   lru_way,
  input  logic            mem_resp,
  output logic            cpu_mem_valid,
  output logic            flush_done,
  output logic [WAYS-1:0] load_data,
  output logic [WAYS-1:0] load_tag,
  output logic            lru_load,
  output logic [WW-1:0]   lru_way_used,
  output logic            mem_read,
  output logic            mem_write,
  output logic [WW-1:0]   wb_way,
  output logic            data_in_select,
  output logic [WAYS-1:0] set_valid,
  output logic [WAYS-1:0] write_valid,
  output logic [WAYS-1:0] set_dirty,
  output logic [WAYS-1:0] write_dirty,
  output logic            flush_active,
  output logic [SW-1:0]   flush_set,
  output logic            error
);
  cc_state_t       state, state_nxt;
  logic [WW-1:0]   vict, vict_sel, fw, hit_idx;
  logic [SW-1:0]   fset;
  logic [WAYS-1:0] oh_vict, oh_fw;
  logic            req, bad, hit, vict_dirty, fw_dirty, flush_last;
  logic            miss_start, flush_start, flush_adv;

  cache_victim_sel #(.WAYS(WAYS)) u_vsel (
    .is_valid (is_valid),
    .lru_way  (lru_way),
    .victim   (vict_sel)
  );

  assign req        = cpu_read | cpu_write;
  assign bad        = (cpu_read & cpu_write) |
                      ((req | cpu_flush) & ~onehot0(MAX_WAYS'(hit_way)));
  assign hit        = |hit_way;
  assign hit_idx    = WW'(first_one(MAX_WAYS'(hit_way)));
  assign vict_dirty = is_valid[vict_sel] & is_dirty[vict_sel] & (WRITE_BACK != 0);
  assign fw_dirty   = is_valid[fw] & is_dirty[fw];
  assign flush_last = (fw == WW'(WAYS-1)) && (fset == SW'(SETS-1));
  assign oh_vict    = WAYS'(1) << vict;
  assign oh_fw      = WAYS'(1) << fw;

  assign miss_start  = (state == CC_IDLE) && !rst && !bad && !cpu_flush && req && !hit;
  assign flush_start = (state == CC_IDLE) && !bad && cpu_flush;
  assign flush_adv   = ((state == CC_FLUSH_CHK) && !fw_dirty) ||
                       ((state == CC_FLUSH_WB) && mem_resp);

  // Outputs decode from state and inputs; reset forces every output low.
  always_comb begin
    state_nxt      = state;
    cpu_mem_valid  = 1'b0;
    flush_done     = 1'b0;
    load_data      = '0;
    load_tag       = '0;
    lru_load       = 1'b0;
    lru_way_used   = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    wb_way         = '0;
    data_in_select = 1'b0;
    set_valid      = '0;
    write_valid    = '0;
    set_dirty      = '0;
    write_dirty    = '0;
    flush_active   = 1'b0;
    flush_set      = '0;
    error          = 1'b0;
    if (!rst) begin
      case (state)
        CC_IDLE: begin
          if (bad) error = 1'b1;
          else if (cpu_flush) state_nxt = CC_FLUSH_CHK;
          else if (req && hit) begin
            lru_load     = 1'b1;
            lru_way_used = hit_idx;
            if (cpu_read) cpu_mem_valid = 1'b1;
            else if (WRITE_BACK != 0) begin
              cpu_mem_valid = 1'b1;
              load_data     = hit_way;
              set_dirty     = hit_way;
              write_dirty   = hit_way;
            end else begin
              load_data = hit_way;
              state_nxt = CC_WT_WRITE;
            end
          end else if (req) begin
            if (cpu_write && WRITE_BACK == 0) state_nxt = CC_WT_WRITE;
            else state_nxt = vict_dirty ? CC_WRITEBACK : CC_ALLOCATE;
          end
        end
        CC_WRITEBACK: begin
          mem_write = 1'b1;
          wb_way    = vict;
          if (mem_resp) state_nxt = CC_ALLOCATE;
        end
        CC_ALLOCATE: begin
          mem_read       = 1'b1;
          data_in_select = 1'b1;
          if (mem_resp) begin
            load_data   = oh_vict;
            load_tag    = oh_vict;
            set_valid   = oh_vict;
            write_valid = oh_vict;
            write_dirty = oh_vict;
            state_nxt   = CC_IDLE;
          end
        end
        CC_WT_WRITE: begin
          mem_write = 1'b1;
          if (mem_resp) begin
            cpu_mem_valid = 1'b1;
            state_nxt     = CC_IDLE;
          end
        end
        CC_FLUSH_CHK: begin
          flush_active = 1'b1;
          flush_set    = fset;
          if (fw_dirty) state_nxt = CC_FLUSH_WB;
          else if (flush_last) begin
            flush_done = 1'b1;
            state_nxt  = CC_IDLE;
          end
        end
        CC_FLUSH_WB: begin
          flush_active = 1'b1;
          flush_set    = fset;
          mem_write    = 1'b1;
          wb_way       = fw;
          if (mem_resp) begin
            write_dirty = oh_fw;
            if (flush_last) begin
              flush_done = 1'b1;
              state_nxt  = CC_IDLE;
            end else state_nxt = CC_FLUSH_CHK;
          end
        end
        default: state_nxt = CC_IDLE;
      endcase
    end
  end

  // Flush counters wrap naturally, so they are back at zero after the last line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CC_IDLE;
      vict  <= '0;
      fw    <= '0;
      fset  <= '0;
    end else begin
      state <= state_nxt;
      if (miss_start) vict <= vict_sel;
      if (flush_start) begin
        fw   <= '0;
        fset <= '0;
      end else if (flush_adv) begin
        fw <= fw + 1'b1;
        if (fw == WW'(WAYS-1)) fset <= fset + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cache_control_nway.sv
// Directed bench: write-back instance for most scenarios, write-through twin for policy check.
module tb_cache_control_nway;
  localparam int WAYS = 4, SETS = 4, WW = 2, SW = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic cpu_read, cpu_write, cpu_flush, mem_resp;
  logic [WAYS-1:0] hit_way, is_valid, is_dirty;
  logic [WW-1:0] lru_way;

  logic cpu_mem_valid, flush_done, lru_load, mem_read, mem_write, data_in_select, flush_active, error;
  logic [WAYS-1:0] load_data, load_tag, set_valid, write_valid, set_dirty, write_dirty;
  logic [WW-1:0] lru_way_used, wb_way;
  logic [SW-1:0] flush_set;

  logic wt_cpu_mem_valid, wt_flush_done, wt_lru_load, wt_mem_read, wt_mem_write, wt_data_in_select, wt_flush_active, wt_error;
  logic [WAYS-1:0] wt_load_data, wt_load_tag, wt_set_valid, wt_write_valid, wt_set_dirty, wt_write_dirty;
  logic [WW-1:0] wt_lru_way_used, wt_wb_way;
  logic [SW-1:0] wt_flush_set;

  logic [37:0] all_out, wt_all_out;
  assign all_out = {cpu_mem_valid, flush_done, load_data, load_tag, lru_load, lru_way_used, mem_read,
                    mem_write, wb_way, data_in_select, set_valid, write_valid, set_dirty, write_dirty,
                    flush_active, flush_set, error};
  assign wt_all_out = {wt_cpu_mem_valid, wt_flush_done, wt_load_data, wt_load_tag, wt_lru_load,
                       wt_lru_way_used, wt_mem_read, wt_mem_write, wt_wb_way, wt_data_in_select,
                       wt_set_valid, wt_write_valid, wt_set_dirty, wt_write_dirty, wt_flush_active,
                       wt_flush_set, wt_error};

  cache_control_nway #(.WAYS(WAYS), .SETS(SETS), .WRITE_BACK(1)) u_wb (
    .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_flush(cpu_flush),
    .hit_way(hit_way), .is_valid(is_valid), .is_dirty(is_dirty), .lru_way(lru_way), .mem_resp(mem_resp),
    .cpu_mem_valid(cpu_mem_valid), .flush_done(flush_done), .load_data(load_data), .load_tag(load_tag),
    .lru_load(lru_load), .lru_way_used(lru_way_used), .mem_read(mem_read), .mem_write(mem_write),
    .wb_way(wb_way), .data_in_select(data_in_select), .set_valid(set_valid), .write_valid(write_valid),
    .set_dirty(set_dirty), .write_dirty(write_dirty), .flush_active(flush_active),
    .flush_set(flush_set), .error(error));

  cache_control_nway #(.WAYS(WAYS), .SETS(SETS), .WRITE_BACK(0)) u_wt (
    .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_flush(cpu_flush),
    .hit_way(hit_way), .is_valid(is_valid), .is_dirty(is_dirty), .lru_way(lru_way), .mem_resp(mem_resp),
    .cpu_mem_valid(wt_cpu_mem_valid), .flush_done(wt_flush_done), .load_data(wt_load_data),
    .load_tag(wt_load_tag), .lru_load(wt_lru_load), .lru_way_used(wt_lru_way_used),
    .mem_read(wt_mem_read), .mem_write(wt_mem_write), .wb_way(wt_wb_way),
    .data_in_select(wt_data_in_select), .set_valid(wt_set_valid), .write_valid(wt_write_valid),
    .set_dirty(wt_set_dirty), .write_dirty(wt_write_dirty), .flush_active(wt_flush_active),
    .flush_set(wt_flush_set), .error(wt_error));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic idle_inputs();
    cpu_read = 0; cpu_write = 0; cpu_flush = 0; mem_resp = 0;
    hit_way = '0; is_valid = '0; is_dirty = '0; lru_way = '0;
  endtask

  task automatic test_reset();
    idle_inputs(); rst = 1; cpu_read = 1; hit_way = 4'b0001;
    @(negedge clk); #1;
    n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL reset_outs got %h want 0", all_out); end
    n_cmp++; if (wt_all_out !== '0) begin n_bad++; $display("FAIL wt_reset_outs got %h want 0", wt_all_out); end
    @(negedge clk); rst = 0; idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL idle_outs[%0d] got %h want 0", i, all_out); end
    end
  endtask

  task automatic test_read_hit();
    @(negedge clk); cpu_read = 1; hit_way = 4'b0100; is_valid = 4'b1111; #1;
    n_cmp++; if (cpu_mem_valid !== 1'b1) begin n_bad++; $display("FAIL rd_hit_valid got %b want 1", cpu_mem_valid); end
    n_cmp++; if (lru_load !== 1'b1 || lru_way_used !== 2'd2) begin n_bad++; $display("FAIL rd_hit_lru got %b/%0d want 1/2", lru_load, lru_way_used); end
    n_cmp++; if (load_data !== 4'b0000 || mem_read !== 1'b0) begin n_bad++; $display("FAIL rd_hit_side got %b/%b want 0000/0", load_data, mem_read); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_write_hit_wb();
    @(negedge clk); cpu_write = 1; hit_way = 4'b0001; is_valid = 4'b1111; #1;
    n_cmp++; if (cpu_mem_valid !== 1'b1 || data_in_select !== 1'b0) begin n_bad++; $display("FAIL wr_hit_valid got %b/%b want 1/0", cpu_mem_valid, data_in_select); end
    n_cmp++; if ({load_data, set_dirty, write_dirty} !== {4'b0001, 4'b0001, 4'b0001}) begin n_bad++; $display("FAIL wr_hit_strobes got %b %b %b want 0001 0001 0001", load_data, set_dirty, write_dirty); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_dirty_miss();
    @(negedge clk); cpu_write = 1; hit_way = 4'b0000; is_valid = 4'b1111; is_dirty = 4'b0010; lru_way = 2'd1; #1;
    n_cmp++; if ({cpu_mem_valid, mem_read, mem_write, error} !== 4'b0000) begin n_bad++; $display("FAIL dm_idle got %b want 0000", {cpu_mem_valid, mem_read, mem_write, error}); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); mem_resp = (k == 2); #1;
      n_cmp++; if ({mem_write, mem_read, wb_way} !== {1'b1, 1'b0, 2'd1}) begin n_bad++; $display("FAIL dm_wb[%0d] got w%b r%b way%0d want w1 r0 way1", k, mem_write, mem_read, wb_way); end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); mem_resp = (k == 1); #1;
      n_cmp++; if ({mem_read, mem_write, data_in_select} !== 3'b101) begin n_bad++; $display("FAIL dm_alloc[%0d] got %b want 101", k, {mem_read, mem_write, data_in_select}); end
      if (k == 0) begin
        n_cmp++; if (load_data !== 4'b0000) begin n_bad++; $display("FAIL dm_early_load got %b want 0000", load_data); end
      end else begin
        n_cmp++; if ({load_data, load_tag, set_valid, write_valid, set_dirty, write_dirty} !==
                     {4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010}) begin
          n_bad++; $display("FAIL dm_fill got %b %b %b %b %b %b want 0010 0010 0010 0010 0000 0010",
                            load_data, load_tag, set_valid, write_valid, set_dirty, write_dirty);
        end
      end
    end
    @(negedge clk); mem_resp = 0; hit_way = 4'b0010; #1;
    n_cmp++; if ({cpu_mem_valid, load_data, mem_read} !== {1'b1, 4'b0010, 1'b0}) begin n_bad++; $display("FAIL dm_rehit got %b %b %b want 1 0010 0", cpu_mem_valid, load_data, mem_read); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_read_miss_invalid();
    @(negedge clk); cpu_read = 1; is_valid = 4'b1011; is_dirty = 4'b1111; lru_way = 2'd0; #1;
    n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL rm_idle got %b want 0", mem_read); end
    @(negedge clk); mem_resp = 1; #1;
    n_cmp++; if ({mem_read, mem_write} !== 2'b10) begin n_bad++; $display("FAIL rm_nowb got %b want 10", {mem_read, mem_write}); end
    n_cmp++; if (load_tag !== 4'b0100) begin n_bad++; $display("FAIL rm_victim got %b want 0100", load_tag); end
    @(negedge clk); mem_resp = 0; hit_way = 4'b0100; #1;
    n_cmp++; if ({cpu_mem_valid, lru_way_used} !== {1'b1, 2'd2}) begin n_bad++; $display("FAIL rm_rehit got %b/%0d want 1/2", cpu_mem_valid, lru_way_used); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clk); cpu_read = 1; is_valid = 4'b1111; lru_way = 2'd3;
    @(negedge clk); #1;
    n_cmp++; if (mem_read !== 1'b1) begin n_bad++; $display("FAIL mr_alloc got %b want 1", mem_read); end
    rst = 1; mem_resp = 1; #1;
    n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL mr_in_reset got %h want 0", all_out); end
    @(negedge clk); rst = 0; idle_inputs(); #1;
    n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL mr_after got %h want 0", all_out); end
  endtask

  task automatic test_write_through();
    @(negedge clk); rst = 1; idle_inputs();
    @(negedge clk); rst = 0; cpu_write = 1; hit_way = 4'b1000; is_valid = 4'b1111; #1;
    n_cmp++; if ({wt_load_data, wt_lru_load, wt_cpu_mem_valid, wt_write_dirty, wt_set_dirty} !== {4'b1000, 1'b1, 1'b0, 4'b0000, 4'b0000}) begin
      n_bad++; $display("FAIL wt_hit got %b %b %b %b %b want 1000 1 0 0000 0000", wt_load_data, wt_lru_load, wt_cpu_mem_valid, wt_write_dirty, wt_set_dirty);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); mem_resp = (k == 2); #1;
      n_cmp++; if ({wt_mem_write, wt_mem_read, wt_cpu_mem_valid, wt_load_data} !== {1'b1, 1'b0, (k == 2), 4'b0000}) begin
        n_bad++; $display("FAIL wt_mem[%0d] got w%b r%b v%b ld%b want w1 r0 v%0d ld0000", k, wt_mem_write, wt_mem_read, wt_cpu_mem_valid, wt_load_data, (k == 2));
      end
    end
    @(negedge clk); idle_inputs(); #1;
    n_cmp++; if (wt_mem_write !== 1'b0) begin n_bad++; $display("FAIL wt_done got %b want 0", wt_mem_write); end
  endtask

  task automatic test_flush();
    int chk = 0, wbs = 0, clr = 0, bad_cmd = 0;
    logic done = 1'b0;
    logic [SW-1:0] done_set = '0;
    @(negedge clk); cpu_flush = 1; cpu_read = 1; hit_way = 4'b0000; is_valid = 4'b1111; is_dirty = 4'b0001; #1;
    n_cmp++; if ({cpu_mem_valid, mem_read, mem_write, error} !== 4'b0000) begin n_bad++; $display("FAIL fl_start got %b want 0000", {cpu_mem_valid, mem_read, mem_write, error}); end
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk); mem_resp = 0; #1;
      if (mem_write) begin
        mem_resp = 1; #1;
        wbs++;
        if (write_dirty == 4'b0001 && set_dirty == 4'b0000 && wb_way == 2'd0) clr++;
      end else if (flush_active) chk++;
      if (mem_read) bad_cmd++;
      if (flush_done) begin done = 1'b1; done_set = flush_set; end
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL fl_done got %b want 1 (timeout)", done); end
    n_cmp++; if (chk != 16) begin n_bad++; $display("FAIL fl_checks got %0d want 16", chk); end
    n_cmp++; if (wbs != 4) begin n_bad++; $display("FAIL fl_writebacks got %0d want 4", wbs); end
    n_cmp++; if (clr != 4) begin n_bad++; $display("FAIL fl_dirty_clear got %0d want 4", clr); end
    n_cmp++; if (done_set !== 2'd3 || bad_cmd != 0) begin n_bad++; $display("FAIL fl_last got set%0d rd%0d want set3 rd0", done_set, bad_cmd); end
    @(negedge clk); mem_resp = 0; cpu_flush = 0; hit_way = 4'b0001; #1;
    n_cmp++; if ({cpu_mem_valid, flush_active, flush_set} !== {1'b1, 1'b0, 2'd0}) begin n_bad++; $display("FAIL fl_then_req got %b %b %0d want 1 0 0", cpu_mem_valid, flush_active, flush_set); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_error();
    @(negedge clk); cpu_read = 1; cpu_write = 1; hit_way = 4'b0001; is_valid = 4'b1111; #1;
    n_cmp++; if (all_out !== 38'd1) begin n_bad++; $display("FAIL err_rw got %h want 1", all_out); end
    @(negedge clk); cpu_write = 0; hit_way = 4'b0011; #1;
    n_cmp++; if ({error, cpu_mem_valid, lru_load} !== 3'b100) begin n_bad++; $display("FAIL err_hit got %b want 100", {error, cpu_mem_valid, lru_load}); end
    @(negedge clk); hit_way = 4'b0001; #1;
    n_cmp++; if ({error, cpu_mem_valid} !== 2'b01) begin n_bad++; $display("FAIL err_recover got %b want 01", {error, cpu_mem_valid}); end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_write_hit_wb();
    test_dirty_miss();
    test_read_miss_invalid();
    test_reset_mid();
    test_write_through();
    test_flush();
    test_error();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
